ram_sync_clear: RTL

//  Parametrised simple-dual-port data RAM for the processor memory subsystem. Adds:
//  - byte-lane write enables
//  - registered (1-cycle) read with a valid flag
//  - selectable read-during-write behaviour
//  - hardware clear sequencer that zeroes the whole array after reset
//  One write port and one read port on a single clock.

---
 rtl/ram_sync_clear.sv | 113 +++++++++++
 1 files changed

// File: rtl/ram_sync_clear.sv
// Simple-dual-port data RAM with byte-lane writes, a registered read with valid flag,
// selectable read-during-write behaviour, and a clear sequencer that zeroes the array after reset.
module ram_sync_clear #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter bit          RDW_NEW_DATA   = 1'b0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [ADDR_WIDTH-1:0]   read_addr,
  input  logic                    re,
  output logic [DATA_WIDTH-1:0]   ram_out,
  output logic                    read_valid,
  output logic                    busy
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clearAddr_q, clearAddr_d;
  logic [DATA_WIDTH-1:0]   ramOut_q, ramOut_d;
  logic                    readValid_q, readValid_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   memAddr;
  logic [NBYTES-1:0]       memByteWe;
  logic [DATA_WIDTH-1:0]   memWdata;
  logic [DATA_WIDTH-1:0]   readWord;

  always_comb begin
    state_d     = state_q;
    clearAddr_d = clearAddr_q;
    ramOut_d    = ramOut_q;
    readValid_d = 1'b0;
    memAddr     = write_addr;
    memByteWe   = '0;
    memWdata    = data;
    readWord    = mem[read_addr];

    case (state_q)
      CLEAR: begin
        memAddr     = clearAddr_q;
        memByteWe   = '1;
        memWdata    = '0;
        clearAddr_d = clearAddr_q + ADDR_WIDTH'(1);
        if (clearAddr_q == '1) begin
          state_d = READY;
        end
      end
      READY: begin
        if (we) begin
          memByteWe = byte_en;
        end
        if (re) begin
          readValid_d = 1'b1;
          // The array write lands at the edge, so bypass the enabled lanes for new-data mode.
          if (RDW_NEW_DATA && we && (write_addr == read_addr)) begin
            for (int i = 0; i < NBYTES; i++) begin
              if (byte_en[i]) begin
                readWord[8*i +: 8] = data[8*i +: 8];
              end
            end
          end
          ramOut_d = readWord;
        end
      end
      default: state_d = READY;
    endcase

    if (reset) begin
      memByteWe = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= CLEAR_ON_RESET ? CLEAR : READY;
      clearAddr_q <= '0;
      ramOut_q    <= '0;
      readValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clearAddr_q <= clearAddr_d;
      ramOut_q    <= ramOut_d;
      readValid_q <= readValid_d;
    end
  end

  // Array itself is never reset so it maps onto byte-enabled block RAM.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (memByteWe[i]) begin
        mem[memAddr][8*i +: 8] <= memWdata[8*i +: 8];
      end
    end
  end

  assign ram_out    = ramOut_q;
  assign read_valid = readValid_q;
  assign busy       = (state_q == CLEAR);

endmodule
